// File: rtl/dsp_dot_sequencer_if.sv
// Bundle of the operand stream, the result stream and the DSP slice
// drive/return signals used by dsp_dot_sequencer.
// slave  : the sequencer side (drives the slice, consumes operands).
// master : the environment side (operand source, result sink, slice P).
interface dsp_dot_sequencer_if;
    // operand stream
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a;
    logic [17:0] in_b;

    // slice drive and return
    logic [17:0] dsp_A;
    logic [17:0] dsp_B;
    logic [7:0]  dsp_OPMODE;
    logic        dsp_CE;
    logic [47:0] dsp_P;

    // result stream
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;

    modport slave (
        input  in_valid, in_a, in_b, dsp_P, out_ready,
        output in_ready, dsp_A, dsp_B, dsp_OPMODE, dsp_CE, out_valid, out_data
    );

    modport master (
        output in_valid, in_a, in_b, dsp_P, out_ready,
        input  in_ready, dsp_A, dsp_B, dsp_OPMODE, dsp_CE, out_valid, out_data
    );
endinterface

// File: rtl/dsp_dot_sequencer.sv
// Streaming dot-product sequencer feeding a DSP48A1-style slice
// (A1REG=B1REG=MREG=PREG=OPMODEREG=1). One multiply is issued per accepted
// operand pair; OPMODE is delayed by OPM_DLY CE-qualified stages so it meets
// the product at the slice post-adder. After the last pair the slice is
// clocked P_LAT-1 more cycles with HOLD, then frozen (CE=0) while P is
// offered as the result. Freezing via CE is the only stall mechanism, so
// input bubbles and output backpressure never disturb the accumulation.
module dsp_dot_sequencer #(
    parameter int LEN     = 8,
    parameter int P_LAT   = 3,
    parameter int OPM_DLY = 1
) (
    input  logic               clk,
    input  logic               rst,
    dsp_dot_sequencer_if.slave bus
);

    localparam int IDX_W  = (LEN > 1)   ? $clog2(LEN)       : 1;
    localparam int DCNT_W = (P_LAT > 2) ? $clog2(P_LAT - 1) : 1;

    localparam logic [7:0] OPM_START = 8'h01; // X=M, Z=0
    localparam logic [7:0] OPM_ACC   = 8'h09; // X=M, Z=P
    localparam logic [7:0] OPM_HOLD  = 8'h08; // X=0, Z=P

    typedef enum logic [1:0] {
        S_FEED  = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;

    logic                ce;
    logic [17:0]         a_drv;
    logic [17:0]         b_drv;
    logic [7:0]          opm_push;

    // Taps of the OPMODE delay line; the last tap feeds the slice.
    logic [OPM_DLY-1:0][7:0] opm_tap;

    // State register: FSM state, pair index and drain counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FEED;
            idx_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Next-state logic and slice drive; CE and OPMODE push are decided here.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dcnt_d    = dcnt_q;
        ce        = 1'b0;
        a_drv     = '0;
        b_drv     = '0;
        opm_push  = OPM_HOLD;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        case (state_q)
            S_FEED: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    ce       = 1'b1;
                    a_drv    = bus.in_a;
                    b_drv    = bus.in_b;
                    opm_push = (idx_q == '0) ? OPM_START : OPM_ACC;
                    if (idx_q == IDX_W'(LEN - 1)) begin
                        state_d = S_DRAIN;
                        idx_d   = '0;
                        dcnt_d  = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                // Keep clocking the slice with zero operands so the last
                // product reaches P; HOLD keeps the sum intact.
                ce       = 1'b1;
                opm_push = OPM_HOLD;
                dcnt_d   = dcnt_q + DCNT_W'(1);
                if (dcnt_q == DCNT_W'(P_LAT - 2)) begin
                    state_d = S_OUT;
                end
            end

            S_OUT: begin
                // Slice frozen, so P (and out_data) is stable until taken.
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_FEED;
                    idx_d   = '0;
                end
            end

            default: begin
                state_d = S_FEED;
                idx_d   = '0;
                dcnt_d  = '0;
            end
        endcase
    end

    // OPMODE delay line: each stage advances only when the slice is clocked.
    for (genvar gi = 0; gi < OPM_DLY; gi++) begin : g_opm
        logic [7:0] stage_q, stage_d;
        logic [7:0] stage_src;

        if (gi == 0) begin : g_first
            assign stage_src = opm_push;
        end else begin : g_rest
            assign stage_src = opm_tap[gi-1];
        end

        // Shift-enable mux for this stage.
        always_comb begin
            stage_d = stage_q;
            if (ce) begin
                stage_d = stage_src;
            end
        end

        // Stage register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= 8'h00;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign opm_tap[gi] = stage_q;
    end

    assign bus.dsp_CE     = ce;
    assign bus.dsp_A      = a_drv;
    assign bus.dsp_B      = b_drv;
    assign bus.dsp_OPMODE = opm_tap[OPM_DLY-1];
    assign bus.out_data   = bus.dsp_P;

endmodule

// File: tb/tb_dsp_dot_sequencer.sv
// Directed bench for dsp_dot_sequencer. Three instances (LEN=4, 1, 2) each
// drive a behavioural DSP48A1-style slice (A1/B1, M, OPMODE, P registers,
// all CE-gated). Expected results are hand-computed constants.
module tb_dsp_dot_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dsp_dot_sequencer_if bus [3] ();

    logic [2:0]  vld_t;
    logic [2:0]  ordy_t;
    logic [17:0] a_t [3];
    logic [17:0] b_t [3];

    logic [2:0]  irdy_t;
    logic [2:0]  ovld_t;
    logic [2:0]  ce_t;
    logic [7:0]  opm_t [3];
    logic [17:0] da_t [3];
    logic [47:0] od_t [3];

    int n_total = 0;
    int n_pass  = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int L = (gi == 0) ? 4 : ((gi == 1) ? 1 : 2);

        dsp_dot_sequencer #(.LEN(L), .P_LAT(3), .OPM_DLY(1)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[gi])
        );

        assign bus[gi].in_valid  = vld_t[gi];
        assign bus[gi].in_a      = a_t[gi];
        assign bus[gi].in_b      = b_t[gi];
        assign bus[gi].out_ready = ordy_t[gi];

        assign irdy_t[gi] = bus[gi].in_ready;
        assign ovld_t[gi] = bus[gi].out_valid;
        assign ce_t[gi]   = bus[gi].dsp_CE;
        assign opm_t[gi]  = bus[gi].dsp_OPMODE;
        assign da_t[gi]   = bus[gi].dsp_A;
        assign od_t[gi]   = bus[gi].out_data;

        // Slice model: A1/B1 -> M -> P, OPMODE registered, all frozen by CE.
        logic signed [17:0] a1_q, b1_q;
        logic signed [35:0] m_q;
        logic [7:0]         opmr_q;
        logic [47:0]        p_q;
        logic [47:0]        xmux, zmux;

        assign xmux = (opmr_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'd0;
        assign zmux = (opmr_q[3:2] == 2'b10) ? p_q : 48'd0;
        assign bus[gi].dsp_P = p_q;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                a1_q   <= '0;
                b1_q   <= '0;
                m_q    <= '0;
                opmr_q <= '0;
                p_q    <= '0;
            end else if (bus[gi].dsp_CE) begin
                a1_q   <= bus[gi].dsp_A;
                b1_q   <= bus[gi].dsp_B;
                m_q    <= a1_q * b1_q;
                opmr_q <= bus[gi].dsp_OPMODE;
                p_q    <= xmux + zmux;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Feed n pairs to instance k with gap idle cycles between pairs, then
    // wait (bounded) for the result. lat counts cycles from last handshake.
    task automatic run_vec(input int k, input int n,
                           input logic [17:0] av [4], input logic [17:0] bv [4],
                           input int gap, output logic [47:0] res, output int lat);
        int w;
        for (int i = 0; i < n; i++) begin
            vld_t[k] = 1'b1;
            a_t[k]   = av[i];
            b_t[k]   = bv[i];
            #1;
            chk("feed_ce", {47'd0, ce_t[k]}, 48'd1);
            chk("feed_a", {30'd0, da_t[k]}, {30'd0, av[i]});
            tick();
            vld_t[k] = 1'b0;
            a_t[k]   = '0;
            b_t[k]   = '0;
            #1;
            chk("issue_opm", {40'd0, opm_t[k]}, (i == 0) ? 48'h01 : 48'h09);
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    chk("gap_ce", {47'd0, ce_t[k]}, 48'd0);
                    chk("gap_opm", {40'd0, opm_t[k]}, (i == 0) ? 48'h01 : 48'h09);
                    tick();
                end
            end
        end
        chk("drain_in_ready", {47'd0, irdy_t[k]}, 48'd0);
        chk("drain_ce", {47'd0, ce_t[k]}, 48'd1);
        lat = 1;
        w   = 0;
        while (ovld_t[k] !== 1'b1 && w < 20) begin
            tick();
            lat++;
            w++;
            if (lat == 2) chk("drain_opm", {40'd0, opm_t[k]}, 48'h08);
        end
        chk("out_valid_seen", {47'd0, ovld_t[k]}, 48'd1);
        res = od_t[k];
    endtask

    task automatic accept(input int k);
        ordy_t[k] = 1'b1;
        tick();
        ordy_t[k] = 1'b0;
        #1;
        chk("acc_in_ready", {47'd0, irdy_t[k]}, 48'd1);
        chk("acc_out_valid", {47'd0, ovld_t[k]}, 48'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] va [4];
        logic [17:0] vb [4];
        logic [47:0] res;
        int          lat;

        rst    = 1'b1;
        vld_t  = '0;
        ordy_t = '0;
        for (int k = 0; k < 3; k++) begin
            a_t[k] = '0;
            b_t[k] = '0;
        end
        repeat (2) tick();
        chk("rst_opm_in_reset", {40'd0, opm_t[0]}, 48'h00);
        rst = 1'b0;
        tick();
        $display("reset released");
        chk("rst_in_ready", {47'd0, irdy_t[0]}, 48'd1);
        chk("rst_out_valid", {47'd0, ovld_t[0]}, 48'd0);
        chk("rst_ce", {47'd0, ce_t[0]}, 48'd0);
        chk("rst_dsp_a", {30'd0, da_t[0]}, 48'd0);
        chk("rst_opm", {40'd0, opm_t[0]}, 48'h00);
        chk("rst_out_data", od_t[0], 48'd0);

        // Basic: [1,2,3,4].[5,6,7,8] = 5+12+21+32 = 70
        va = '{18'd1, 18'd2, 18'd3, 18'd4};
        vb = '{18'd5, 18'd6, 18'd7, 18'd8};
        run_vec(0, 4, va, vb, 0, res, lat);
        $display("basic: result=%0d latency=%0d", res, lat);
        chk("basic_lat", 48'(lat), 48'd3);
        chk("basic_data", res, 48'd70);
        accept(0);

        // Signed LEN=1: -3 * 7 = -21
        va = '{18'h3FFFD, 18'd0, 18'd0, 18'd0};
        vb = '{18'd7, 18'd0, 18'd0, 18'd0};
        run_vec(1, 1, va, vb, 0, res, lat);
        $display("signed: result=%0h latency=%0d", res, lat);
        chk("signed_lat", 48'(lat), 48'd3);
        chk("signed_data", res, 48'hFFFF_FFFF_FFEB);
        accept(1);

        // Bubbles: same data, two idle cycles between pairs
        va = '{18'd1, 18'd2, 18'd3, 18'd4};
        vb = '{18'd5, 18'd6, 18'd7, 18'd8};
        run_vec(0, 4, va, vb, 2, res, lat);
        $display("bubbles: result=%0d latency=%0d", res, lat);
        chk("bubble_lat", 48'(lat), 48'd3);
        chk("bubble_data", res, 48'd70);
        accept(0);

        // Back-to-back on LEN=2: [2,2].[3,3]=12 then [1,1].[1,1]=2
        va = '{18'd2, 18'd2, 18'd0, 18'd0};
        vb = '{18'd3, 18'd3, 18'd0, 18'd0};
        run_vec(2, 2, va, vb, 0, res, lat);
        $display("b2b first: result=%0d", res);
        chk("b2b_first", res, 48'd12);
        accept(2);
        va = '{18'd1, 18'd1, 18'd0, 18'd0};
        vb = '{18'd1, 18'd1, 18'd0, 18'd0};
        run_vec(2, 2, va, vb, 0, res, lat);
        $display("b2b second: result=%0d", res);
        chk("b2b_second", res, 48'd2);
        accept(2);

        // Backpressure: result held 5 cycles with in_valid asserted
        va = '{18'd1, 18'd2, 18'd3, 18'd4};
        vb = '{18'd5, 18'd6, 18'd7, 18'd8};
        run_vec(0, 4, va, vb, 0, res, lat);
        vld_t[0] = 1'b1;
        a_t[0]   = 18'd9;
        b_t[0]   = 18'd9;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_out_data", od_t[0], 48'd70);
            chk("bp_in_ready", {47'd0, irdy_t[0]}, 48'd0);
            chk("bp_out_valid", {47'd0, ovld_t[0]}, 48'd1);
            chk("bp_ce", {47'd0, ce_t[0]}, 48'd0);
            tick();
        end
        $display("backpressure: held result=%0d", od_t[0]);
        vld_t[0] = 1'b0;
        a_t[0]   = '0;
        b_t[0]   = '0;
        accept(0);
        run_vec(0, 4, va, vb, 0, res, lat);
        $display("after backpressure: result=%0d", res);
        chk("post_bp_data", res, 48'd70);
        accept(0);

        // Reset after two of four pairs, then a full vector
        vld_t[0] = 1'b1; a_t[0] = 18'd1; b_t[0] = 18'd5; tick();
        vld_t[0] = 1'b1; a_t[0] = 18'd2; b_t[0] = 18'd6; tick();
        vld_t[0] = 1'b0; a_t[0] = '0;    b_t[0] = '0;
        #1;
        chk("pre_rst_opm", {40'd0, opm_t[0]}, 48'h09);
        rst = 1'b1;
        #1;
        chk("mid_rst_opm", {40'd0, opm_t[0]}, 48'h00);
        chk("mid_rst_ce", {47'd0, ce_t[0]}, 48'd0);
        chk("mid_rst_in_ready", {47'd0, irdy_t[0]}, 48'd1);
        chk("mid_rst_out_valid", {47'd0, ovld_t[0]}, 48'd0);
        chk("mid_rst_out_data", od_t[0], 48'd0);
        tick();
        rst = 1'b0;
        tick();
        run_vec(0, 4, va, vb, 0, res, lat);
        $display("after reset: result=%0d latency=%0d", res, lat);
        chk("post_rst_data", res, 48'd70);
        chk("post_rst_lat", 48'(lat), 48'd3);
        accept(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dsp_dot_sequencer.md
# dsp_dot_sequencer

Streaming dot-product sequencer that sits directly upstream of the DSP48A1-style slice and drives its A, B, OPMODE and clock-enable inputs. It accepts LEN operand pairs over a valid/ready handshake and issues one multiply per accepted pair. It aligns OPMODE with the slice's internal pipeline, drains the pipeline after the last pair, and presents the slice's accumulated P as a single result with valid/ready.

## Interface
- LEN, 8: operand pairs per dot product; legal range is ≥1.
- P_LAT, 3: CE-high cycles from operand issue to P holding the result; legal range is ≥2.
- OPM_DLY, 1: CE-high cycles between operand issue and the matching OPMODE presentation.
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- in_a  in  18  signed multiplicand
- in_b  in  18  signed multiplier
- dsp_A  out  18  to slice A
- dsp_B  out  18  to slice B
- dsp_OPMODE  out  8  to slice OPMODE
- dsp_CE  out  1  to every slice CE input
- dsp_P  in  48  from slice P
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_data  out  48  signed dot product

## Operation
- **Required slice configuration:**
  - A0REG=0, B0REG=0, A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1.
  - B_INPUT="DIRECT", CARRYINSEL="OPMODE5".
  - Every slice CE is tied to dsp_CE.
  - With this configuration, P_LAT=3 and OPM_DLY=1.
- **Freeze mechanism:** dsp_CE low freezes the entire slice and the internal OPMODE delay line. This is the only stall mechanism.
- **OPMODE codes:**
  - 0x01 (START): X=M, Z=0.
  - 0x09 (ACC): X=M, Z=P.
  - 0x08 (HOLD): X=0, Z=P.
  - Bits 4–7 are always 0: no pre-adder, no carry-in, add.
- **OPMODE delay line:** OPM_DLY registers, shifted only when dsp_CE=1. dsp_OPMODE is the last stage.
- **States:**
  - FEED: in_ready=1; dsp_CE=in_valid; dsp_A/dsp_B=in_a/in_b.
    - On handshake, push START if idx==0, else ACC; then idx++.
    - If the handshake has idx==LEN-1, go to DRAIN with dcnt=0.
    - With no handshake: dsp_A=dsp_B=0, dsp_CE=0.
  - DRAIN: in_ready=0; dsp_CE=1; dsp_A=dsp_B=0; push HOLD each cycle; dcnt++.
    - When dcnt==P_LAT-2, go to OUT.
  - OUT: in_ready=0; dsp_CE=0, so the slice is frozen; out_valid=1; out_data=dsp_P.
    - On out_ready, go to FEED with idx=0.
- **Arithmetic:** the 18×18 signed product accumulates in the 48-bit P. Overflow beyond 48 bits wraps with no flag.

## Timing
- **Reset values:**
  - state=FEED, idx=0, dcnt=0.
  - Delay line=0x00, so dsp_OPMODE=0x00.
  - dsp_CE=0, dsp_A=dsp_B=0.
  - out_valid=0, out_data passes dsp_P; in_ready=1 after reset release.
- **Result latency:** if the last pair handshakes in cycle t, DRAIN occupies cycles t+1 … t+P_LAT-1 and out_valid rises in cycle t+P_LAT.
  - LEN=1 behaves identically, using START only.
- **Bubbles:** in_valid gaps freeze the slice and the delay line, so the result is independent of gap pattern and length.
- **Back-to-back vectors:** in the cycle after the out_ready handshake, in_ready=1. The first pair of the next vector uses START, so there is no carry-over of the previous sum.
- **Output stability:** out_data is stable while out_valid=1 and out_ready=0, because the slice is frozen.
- **Output handshake:** no combinational path from out_ready to out_valid. in_ready depends only on state.
- **Reset mid-operation:** any state returns immediately to the reset values and the partial sum is discarded. The slice's RST* inputs are driven from RST by the integrator.

## Test plan
- **Basic dot product:** LEN=4, a=[1,2,3,4], b=[5,6,7,8] with continuous in_valid → out_valid 3 cycles after the 4th handshake, out_data=70.
- **Signed operands:** LEN=1, a=18'h3FFFD (-3), b=7 → out_data=48'hFFFF_FFFF_FFEB (-21); dsp_OPMODE sequence is 0x01, then 0x08.
- **Bubbles:** LEN=4 with the same data and in_valid low for 2 cycles between each pair → out_data=70; dsp_CE=0 and dsp_OPMODE unchanged during the gaps.
- **Back-to-back vectors:** vector [2,2]·[3,3] then [1,1]·[1,1] → results 12 then 2; the second vector's first issued OPMODE is 0x01.
- **Output backpressure:** out_ready held low for 5 cycles → out_data constant, in_ready=0, in_valid ignored; accepted on the 6th cycle.
- **Reset mid-FEED:** assert RST after 2 of 4 pairs → outputs return to their reset values at once; the next full vector [1,2,3,4]·[5,6,7,8] yields 70.
